// File: rtl/reg_file.sv
// Integer register file: 32 x 32-bit, x0 reads as zero, two combinational read
// ports with write-to-read bypass, and a saturating count of committed writes.
module reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  output logic [15:0]       writeCount
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [15:0]       count;
  logic              commit;

  assign commit = writeEnable && (writeAddr != '0);

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      regs  <= '{default: '0};
      count <= '0;
    end else if (commit) begin
      regs[writeAddr] <= writeData;
      if (count != '1)
        count <= count + 16'd1;
    end
  end

  // Reads are forced to zero while reset is held, so the async clear is
  // visible on the ports before any clock edge.
  always_comb begin
    readData1 = '0;
    if (resetIn && (readAddr1 != '0))
      readData1 = (writeEnable && (writeAddr == readAddr1)) ? writeData : regs[readAddr1];
  end

  always_comb begin
    readData2 = '0;
    if (resetIn && (readAddr2 != '0))
      readData2 = (writeEnable && (writeAddr == readAddr2)) ? writeData : regs[readAddr2];
  end

  assign writeCount = count;

endmodule

// File: tb/tb_reg_file.sv
// Randomised scoreboard bench for reg_file: stimulus pushes expected port values,
// a negedge monitor pops and compares them against the live outputs.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        resetIn;
  logic [4:0]  readAddr1, readAddr2, writeAddr;
  logic [31:0] readData1, readData2, writeData;
  logic        writeEnable;
  logic [15:0] writeCount;

  reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .resetIn(resetIn),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(readData1), .readData2(readData2),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .writeCount(writeCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [32];
  int          cnt_model;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!resetIn || a == 5'd0) return 32'd0;
    if (writeEnable && writeAddr == a) return writeData;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    cnt_model = 0;
  endtask

  task automatic push_exp(input string nm);
    exp_t e;
    e.name = nm;
    e.d1   = exp_rd(readAddr1);
    e.d2   = exp_rd(readAddr2);
    e.cnt  = cnt_model[15:0];
    q.push_back(e);
  endtask

  // Drive one cycle's inputs just after a rising edge, then let the edge commit.
  task automatic apply(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input bit chk, input string nm);
    resetIn = r; readAddr1 = a1; readAddr2 = a2;
    writeEnable = w; writeAddr = wa; writeData = wd;
    if (!r) clear_model();
    if (chk) push_exp(nm);
    @(posedge clk);
    if (r && w && wa != 5'd0) begin
      model[wa] = wd;
      if (cnt_model < 65535) cnt_model++;
    end
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (readData1 !== e.d1) begin
        n_fail++;
        $display("FAIL %s readData1 got %h expected %h (t=%0t)", e.name, readData1, e.d1, $time);
      end
      n_checks++;
      if (readData2 !== e.d2) begin
        n_fail++;
        $display("FAIL %s readData2 got %h expected %h (t=%0t)", e.name, readData2, e.d2, $time);
      end
      n_checks++;
      if (writeCount !== e.cnt) begin
        n_fail++;
        $display("FAIL %s writeCount got %h expected %h (t=%0t)", e.name, writeCount, e.cnt, $time);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    resetIn = 1'b0; readAddr1 = '0; readAddr2 = '0;
    writeEnable = 1'b0; writeAddr = '0; writeData = '0;

    apply(0, 5, 3, 1, 5, 32'hFFFF_FFFF, 1, "reset_init");
    apply(0, 1, 31, 0, 0, 0, 1, "reset_init2");

    // basic write then read on both ports
    apply(1, 3, 0, 1, 3, 32'h1234_5678, 1, "write_x3_bypass");
    apply(1, 3, 3, 0, 0, 0, 1, "read_x3");

    // x0 protection
    apply(1, 0, 3, 1, 0, 32'hFFFF_FFFF, 1, "x0_during");
    apply(1, 0, 0, 0, 0, 0, 1, "x0_after");

    // bypass on port 2
    apply(1, 0, 7, 1, 7, 32'h0000_0011, 1, "x7_init");
    apply(1, 0, 7, 1, 7, 32'h0000_0022, 1, "bypass_x7");
    apply(1, 7, 7, 0, 7, 32'h0000_0033, 1, "x7_after");

    // dual-port independence and swap
    apply(1, 0, 0, 1, 1, 32'hA, 1, "wr_x1");
    apply(1, 0, 0, 1, 2, 32'hB, 1, "wr_x2");
    apply(1, 1, 2, 0, 0, 0, 1, "dual_12");
    apply(1, 2, 1, 0, 0, 0, 1, "dual_21");

    // random traffic with occasional resets and frequent read/write collisions
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a1, a2, wa;
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      apply(($urandom_range(0, 39) != 0), a1, a2, 1'($urandom_range(0, 1)), wa, $urandom, 1, "random");
    end

    // short async reset pulse with no clock edge inside it
    apply(1, 5, 0, 1, 5, 32'hDEAD_BEEF, 1, "wr_x5");
    apply(1, 5, 5, 0, 0, 0, 1, "rd_x5");
    resetIn = 1'b0; writeEnable = 1'b1; writeAddr = 5'd9; writeData = 32'h5555_AAAA;
    clear_model();
    push_exp("async_reset_now");
    @(negedge clk); #1;
    resetIn = 1'b1; writeEnable = 1'b0;
    push_exp("after_glitch_x5");
    @(posedge clk); #1;
    apply(1, 9, 5, 0, 0, 0, 1, "after_glitch_x9");

    // write during held reset is lost
    apply(0, 4, 0, 1, 4, 32'h0BAD_F00D, 1, "reset_mid_write");
    apply(1, 4, 0, 0, 0, 0, 1, "after_mid_write");

    // sweep all registers
    for (int i = 1; i < 32; i++)
      apply(1, 0, 0, 1, 5'(i), 32'(i) * 32'h0101_0101, 0, "sweep_wr");
    for (int i = 0; i < 32; i++)
      apply(1, 5'(i), 5'((i + 1) % 32), 0, 0, 0, 1, "sweep_rd");

    // drive the write counter into saturation
    for (int i = 0; i < 70000; i++)
      apply(1, 5'($urandom_range(0, 31)), 0, 1, 5'($urandom_range(1, 31)), $urandom,
            (i % 5000 == 0) || (i > 69990), "saturate");
    apply(1, 1, 31, 1, 0, 32'h1, 1, "sat_x0_write");
    apply(1, 1, 31, 0, 0, 0, 1, "sat_hold");

    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain %0d pending expectations, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
